arm_mc_controller: RTL and testbench

Multicycle control unit for the ARM core: replaces the hardwired single-instruction control values at the core top with a finite state machine. It decodes data-processing (ADD, SUB, AND, ORR, CMP, optional EOR), LDR/STR with immediate offset, and B instructions. It holds the NZCV flags register and applies ARM conditional execution. It sits between the instruction register and the shared-memory multicycle datapath.

---
 rtl/arm_mc_controller.sv | 209 ++++++++++++++++++++
 tb/tb_arm_mc_controller.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/arm_mc_controller.sv
`default_nettype none
// ============================================================================
// Module   : arm_mc_controller
// Purpose  : Multicycle ARM control unit. It is a Moore FSM that sequences
//            fetch/decode/execute over a shared-memory datapath. It holds the
//            NZCV flags and gates writes with the ARM condition check.
// Revision : 1.0 - initial release
// ============================================================================
module arm_mc_controller #(
    parameter int ALUCTRL_W = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [19:0]          Instr,
    input  logic [3:0]           ALUFlags,
    output logic                 PCWrite,
    output logic                 MemWrite,
    output logic                 RegWrite,
    output logic                 IRWrite,
    output logic                 AdrSrc,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [3:0]           Flags,
    output logic [3:0]           State
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4, S_MEMWR  = 4'd5, S_EXECR  = 4'd6, S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8, S_BRANCH = 4'd9
    } state_t;

    localparam logic [2:0] c_ALU_ADD = 3'd0;
    localparam logic [2:0] c_ALU_SUB = 3'd1;
    localparam logic [2:0] c_ALU_AND = 3'd2;
    localparam logic [2:0] c_ALU_ORR = 3'd3;
    localparam logic [2:0] c_ALU_EOR = 3'd4;

    state_t     r_state, w_next;
    logic       r_cond_ok;
    logic [3:0] r_flags;

    // Instr carries bits [31:12] of the instruction word
    logic [3:0] w_cond, w_cmd, w_rd;
    logic [1:0] w_op;
    logic       w_i, w_s;
    assign w_cond = Instr[19:16];
    assign w_op   = Instr[15:14];
    assign w_i    = Instr[13];
    assign w_cmd  = Instr[12:9];
    assign w_s    = Instr[8];      // S for data-processing, L for memory
    assign w_rd   = Instr[3:0];

    logic       w_dp_ok, w_is_cmp, w_cond_ex, w_cv_upd;
    logic [2:0] w_dp_alu, w_alu_op;
    logic       w_n, w_z, w_c, w_v;
    assign {w_n, w_z, w_c, w_v} = r_flags;

    // Rn is consumed by the datapath only; EOR bit is dropped at width 2
    logic w_unused_bits;
    assign w_unused_bits = ^{Instr[7:4], w_alu_op[2]};

    // Data-processing command decode: legality, ALU op, CMP detection
    always_comb begin
        w_dp_ok  = 1'b0;
        w_dp_alu = c_ALU_ADD;
        w_is_cmp = 1'b0;
        case (w_cmd)
            4'b0100: begin w_dp_ok = 1'b1; w_dp_alu = c_ALU_ADD; end
            4'b0010: begin w_dp_ok = 1'b1; w_dp_alu = c_ALU_SUB; end
            4'b0000: begin w_dp_ok = 1'b1; w_dp_alu = c_ALU_AND; end
            4'b1100: begin w_dp_ok = 1'b1; w_dp_alu = c_ALU_ORR; end
            4'b1010: begin w_dp_ok = w_s;  w_dp_alu = c_ALU_SUB; w_is_cmp = 1'b1; end
            4'b0001: begin w_dp_ok = (ALUCTRL_W == 3); w_dp_alu = c_ALU_EOR; end
            default: w_dp_ok = 1'b0;
        endcase
    end

    assign w_cv_upd = (w_dp_alu == c_ALU_ADD) || (w_dp_alu == c_ALU_SUB);

    // ARM condition evaluation against the registered flags; NV never executes
    always_comb begin
        w_cond_ex = 1'b0;
        case (w_cond)
            4'b0000: w_cond_ex = w_z;
            4'b0001: w_cond_ex = ~w_z;
            4'b0010: w_cond_ex = w_c;
            4'b0011: w_cond_ex = ~w_c;
            4'b0100: w_cond_ex = w_n;
            4'b0101: w_cond_ex = ~w_n;
            4'b0110: w_cond_ex = w_v;
            4'b0111: w_cond_ex = ~w_v;
            4'b1000: w_cond_ex = w_c & ~w_z;
            4'b1001: w_cond_ex = ~w_c | w_z;
            4'b1010: w_cond_ex = (w_n == w_v);
            4'b1011: w_cond_ex = (w_n != w_v);
            4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
            4'b1101: w_cond_ex = w_z | (w_n != w_v);
            4'b1110: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    // State register, latched condition result and NZCV flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_cond_ok <= 1'b0;
            r_flags   <= 4'b0000;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE)
                r_cond_ok <= w_cond_ex;
            if ((r_state == S_EXECR || r_state == S_EXECI) && w_s && r_cond_ok) begin
                r_flags[3:2] <= ALUFlags[3:2];
                if (w_cv_upd)
                    r_flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    // Next-state selection and Moore output decode; reset forces FETCH selects
    always_comb begin
        w_next    = S_FETCH;
        PCWrite   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        w_alu_op  = c_ALU_ADD;
        case (r_state)
            S_FETCH: w_next = S_DECODE;
            S_DECODE: begin
                case (w_op)
                    2'b01:   w_next = S_MEMADR;
                    2'b00:   w_next = w_dp_ok ? (w_i ? S_EXECI : S_EXECR) : S_FETCH;
                    2'b10:   w_next = S_BRANCH;
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_next = w_s ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = S_MEMWB;
            S_EXECR:  w_next = S_ALUWB;
            S_EXECI:  w_next = S_ALUWB;
            default:  w_next = S_FETCH;
        endcase
        if (reset) begin
            ResultSrc = 2'b10;
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
        end else begin
            case (r_state)
                S_FETCH: begin
                    IRWrite   = 1'b1;
                    PCWrite   = 1'b1;
                    ALUSrcA   = 2'b01;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                end
                S_DECODE: begin
                    ALUSrcA   = 2'b01;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                end
                S_MEMADR: ALUSrcB = 2'b01;
                S_MEMRD:  AdrSrc  = 1'b1;
                S_MEMWB: begin
                    ResultSrc = 2'b01;
                    RegWrite  = r_cond_ok;
                end
                S_MEMWR: begin
                    AdrSrc   = 1'b1;
                    MemWrite = r_cond_ok;
                end
                S_EXECR: w_alu_op = w_dp_alu;
                S_EXECI: begin
                    ALUSrcB  = 2'b01;
                    w_alu_op = w_dp_alu;
                end
                S_ALUWB: begin
                    RegWrite = r_cond_ok & ~w_is_cmp;
                    PCWrite  = r_cond_ok & ~w_is_cmp & (w_rd == 4'hF);
                end
                S_BRANCH: begin
                    ALUSrcA   = 2'b01;
                    ALUSrcB   = 2'b01;
                    ResultSrc = 2'b10;
                    PCWrite   = r_cond_ok;
                end
                default: ;
            endcase
        end
    end

    assign ALUControl = w_alu_op[ALUCTRL_W-1:0];
    assign ImmSrc     = w_op;
    assign RegSrc     = {w_op == 2'b01, w_op == 2'b10};
    assign Flags      = r_flags;
    assign State      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_arm_mc_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_arm_mc_controller
// Purpose  : Scoreboard bench for arm_mc_controller (ALUCTRL_W=3 main DUT,
//            ALUCTRL_W=2 companion DUT sharing the same stimulus).
// Revision : 1.0 - initial release
// ============================================================================
module tb_arm_mc_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] Instr = 20'h0;
    logic [3:0]  ALUFlags = 4'h0;

    logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc;
    logic [2:0] ALUControl;
    logic [3:0] Flags, State;

    logic       d2_PCWrite, d2_MemWrite, d2_RegWrite, d2_IRWrite, d2_AdrSrc;
    logic [1:0] d2_ResultSrc, d2_ALUSrcA, d2_ALUSrcB, d2_ImmSrc, d2_RegSrc;
    logic [1:0] d2_ALUControl;
    logic [3:0] d2_Flags, d2_State;

    arm_mc_controller #(.ALUCTRL_W(3)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
        .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
        .Flags(Flags), .State(State)
    );

    arm_mc_controller #(.ALUCTRL_W(2)) dut2 (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(d2_PCWrite), .MemWrite(d2_MemWrite), .RegWrite(d2_RegWrite),
        .IRWrite(d2_IRWrite), .AdrSrc(d2_AdrSrc), .ResultSrc(d2_ResultSrc),
        .ALUSrcA(d2_ALUSrcA), .ALUSrcB(d2_ALUSrcB), .ImmSrc(d2_ImmSrc),
        .RegSrc(d2_RegSrc), .ALUControl(d2_ALUControl),
        .Flags(d2_Flags), .State(d2_State)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [3:0] st;
        logic       pcw, mw, rw, irw, adr;
        logic [1:0] res, sa, sb;
        logic [2:0] alu;
        logic [3:0] fl;
        logic [3:0] isrs;
        logic [3:0] st2;
        logic       rw2;
    } exp_t;

    exp_t  q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    logic [3:0]  exp_flags = 4'h0;
    logic [3:0]  cur_isrs  = 4'h0;
    logic [19:0] nxt_instr = 20'h0;
    string       cur_name  = "reset";
    int          cyc_idx   = 0;

    // Begin a new instruction; Instr changes at its FETCH cycle
    task automatic start(input string name, input logic [19:0] ins, input logic [3:0] isrs);
        cur_name  = name;
        cyc_idx   = 0;
        nxt_instr = ins;
        cur_isrs  = isrs;
    endtask

    // One clock of stimulus plus the expected outputs for that cycle
    task automatic cyc_full(input logic [3:0] st, input logic pcw, input logic mw,
                            input logic rw, input logic [2:0] alu, input logic [3:0] af,
                            input logic [3:0] st2, input logic rw2, input logic rst);
        exp_t e;
        @(posedge clk); #1;
        reset    = rst;
        ALUFlags = af;
        Instr    = nxt_instr;
        e.tag = $sformatf("%s.c%0d", cur_name, cyc_idx);
        cyc_idx++;
        e.st  = st;
        e.pcw = rst ? 1'b0 : pcw;
        e.mw  = rst ? 1'b0 : mw;
        e.rw  = rst ? 1'b0 : rw;
        e.irw = !rst && (st == 4'd0);
        e.alu = rst ? 3'd0 : alu;
        if (rst) {e.adr, e.res, e.sa, e.sb} = 7'b0_10_01_10;
        else begin
            case (st)
                4'd0, 4'd1: {e.adr, e.res, e.sa, e.sb} = 7'b0_10_01_10;
                4'd2:       {e.adr, e.res, e.sa, e.sb} = 7'b0_00_00_01;
                4'd3, 4'd5: {e.adr, e.res, e.sa, e.sb} = 7'b1_00_00_00;
                4'd4:       {e.adr, e.res, e.sa, e.sb} = 7'b0_01_00_00;
                4'd7:       {e.adr, e.res, e.sa, e.sb} = 7'b0_00_00_01;
                4'd9:       {e.adr, e.res, e.sa, e.sb} = 7'b0_10_01_01;
                default:    {e.adr, e.res, e.sa, e.sb} = 7'b0_00_00_00;
            endcase
        end
        e.fl   = exp_flags;
        e.isrs = cur_isrs;
        e.st2  = st2;
        e.rw2  = rst ? 1'b0 : rw2;
        q.push_back(e);
    endtask

    task automatic cyc(input logic [3:0] st, input logic pcw, input logic mw,
                       input logic rw, input logic [2:0] alu, input logic [3:0] af);
        cyc_full(st, pcw, mw, rw, alu, af, st, rw, 1'b0);
    endtask

    // Monitor: pop and compare once per cycle, away from the active edge
    exp_t        m_e;
    logic [25:0] m_act, m_exp;
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                m_e   = q.pop_front();
                m_act = {State, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
                         ResultSrc, ALUSrcA, ALUSrcB, ALUControl, Flags, ImmSrc, RegSrc};
                m_exp = {m_e.st, m_e.pcw, m_e.mw, m_e.rw, m_e.irw, m_e.adr,
                         m_e.res, m_e.sa, m_e.sb, m_e.alu, m_e.fl, m_e.isrs};
                n_tests++;
                if (m_act !== m_exp) begin
                    n_fail++;
                    $display("FAIL %s: got st=%0d pcw/mw/rw/irw/adr=%b%b%b%b%b res=%b sa=%b sb=%b alu=%0d fl=%b is/rs=%b, expected %h (got %h)",
                             m_e.tag, State, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
                             ResultSrc, ALUSrcA, ALUSrcB, ALUControl, Flags, {ImmSrc, RegSrc},
                             m_exp, m_act);
                end
                n_tests++;
                if ({d2_State, d2_RegWrite} !== {m_e.st2, m_e.rw2}) begin
                    n_fail++;
                    $display("FAIL %s.w2: got st=%0d rw=%b, expected st=%0d rw=%b",
                             m_e.tag, d2_State, d2_RegWrite, m_e.st2, m_e.rw2);
                end
            end
        end
    end

    // Directed instruction stream with hand-computed per-cycle expectations
    initial begin
        start("reset", 20'h00000, 4'b0000);
        cyc_full(4'd0, 0, 0, 0, 3'd0, 4'hF, 4'd0, 0, 1'b1);
        cyc_full(4'd0, 0, 0, 0, 3'd0, 4'hF, 4'd0, 0, 1'b1);

        start("orr", 20'hE1821, 4'b0000);
        cyc(4'd0, 1, 0, 0, 3'd0, 4'hF); cyc(4'd1, 0, 0, 0, 3'd0, 4'hF);
        cyc(4'd6, 0, 0, 0, 3'd3, 4'hF); cyc(4'd8, 0, 0, 1, 3'd0, 4'hF);

        start("subs", 20'hE2500, 4'b0000);
        cyc(4'd0, 1, 0, 0, 3'd0, 4'hF); cyc(4'd1, 0, 0, 0, 3'd0, 4'hF);
        cyc(4'd7, 0, 0, 0, 3'd1, 4'b0110);
        exp_flags = 4'b0110;
        cyc(4'd8, 0, 0, 1, 3'd0, 4'hF);

        start("addeq", 20'h02811, 4'b0000);
        cyc(4'd0, 1, 0, 0, 3'd0, 4'hF); cyc(4'd1, 0, 0, 0, 3'd0, 4'hF);
        cyc(4'd7, 0, 0, 0, 3'd0, 4'hF); cyc(4'd8, 0, 0, 1, 3'd0, 4'hF);

        start("addne", 20'h12811, 4'b0000);
        cyc(4'd0, 1, 0, 0, 3'd0, 4'hF); cyc(4'd1, 0, 0, 0, 3'd0, 4'hF);
        cyc(4'd7, 0, 0, 0, 3'd0, 4'hF); cyc(4'd8, 0, 0, 0, 3'd0, 4'hF);

        start("cmp", 20'hE3500, 4'b0000);
        cyc(4'd0, 1, 0, 0, 3'd0, 4'hF); cyc(4'd1, 0, 0, 0, 3'd0, 4'hF);
        cyc(4'd7, 0, 0, 0, 3'd1, 4'b1000);
        exp_flags = 4'b1000;
        cyc(4'd8, 0, 0, 0, 3'd0, 4'hF);

        start("beq", 20'h0A000, 4'b1001);
        cyc(4'd0, 1, 0, 0, 3'd0, 4'hF); cyc(4'd1, 0, 0, 0, 3'd0, 4'hF);
        cyc(4'd9, 0, 0, 0, 3'd0, 4'hF);

        start("bne", 20'h1A000, 4'b1001);
        cyc(4'd0, 1, 0, 0, 3'd0, 4'hF); cyc(4'd1, 0, 0, 0, 3'd0, 4'hF);
        cyc(4'd9, 1, 0, 0, 3'd0, 4'hF);

        start("ands", 20'hE2122, 4'b0000);
        cyc(4'd0, 1, 0, 0, 3'd0, 4'hF); cyc(4'd1, 0, 0, 0, 3'd0, 4'hF);
        cyc(4'd7, 0, 0, 0, 3'd2, 4'b0111);
        exp_flags = 4'b0100;
        cyc(4'd8, 0, 0, 1, 3'd0, 4'hF);

        start("addpc", 20'hE080F, 4'b0000);
        cyc(4'd0, 1, 0, 0, 3'd0, 4'hF); cyc(4'd1, 0, 0, 0, 3'd0, 4'hF);
        cyc(4'd6, 0, 0, 0, 3'd0, 4'hF); cyc(4'd8, 1, 0, 1, 3'd0, 4'hF);

        start("ldr", 20'hE5954, 4'b0110);
        cyc(4'd0, 1, 0, 0, 3'd0, 4'hF); cyc(4'd1, 0, 0, 0, 3'd0, 4'hF);
        cyc(4'd2, 0, 0, 0, 3'd0, 4'hF); cyc(4'd3, 0, 0, 0, 3'd0, 4'hF);
        cyc(4'd4, 0, 0, 1, 3'd0, 4'hF);

        start("str", 20'hE5854, 4'b0110);
        cyc(4'd0, 1, 0, 0, 3'd0, 4'hF); cyc(4'd1, 0, 0, 0, 3'd0, 4'hF);
        cyc(4'd2, 0, 0, 0, 3'd0, 4'hF); cyc(4'd5, 0, 1, 0, 3'd0, 4'hF);

        start("str_abort", 20'hE5854, 4'b0110);
        cyc(4'd0, 1, 0, 0, 3'd0, 4'hF); cyc(4'd1, 0, 0, 0, 3'd0, 4'hF);
        cyc_full(4'd2, 0, 0, 0, 3'd0, 4'hF, 4'd2, 0, 1'b1);
        exp_flags = 4'b0000;
        cyc_full(4'd0, 0, 0, 0, 3'd0, 4'hF, 4'd0, 0, 1'b1);

        start("op11", 20'hEC000, 4'b1100);
        cyc(4'd0, 1, 0, 0, 3'd0, 4'hF); cyc(4'd1, 0, 0, 0, 3'd0, 4'hF);

        start("rsb", 20'hE0600, 4'b0000);
        cyc(4'd0, 1, 0, 0, 3'd0, 4'hF); cyc(4'd1, 0, 0, 0, 3'd0, 4'hF);

        start("cmp_nos", 20'hE1400, 4'b0000);
        cyc(4'd0, 1, 0, 0, 3'd0, 4'hF); cyc(4'd1, 0, 0, 0, 3'd0, 4'hF);

        start("addnv", 20'hF2811, 4'b0000);
        cyc(4'd0, 1, 0, 0, 3'd0, 4'hF); cyc(4'd1, 0, 0, 0, 3'd0, 4'hF);
        cyc(4'd7, 0, 0, 0, 3'd0, 4'hF); cyc(4'd8, 0, 0, 0, 3'd0, 4'hF);

        start("eor", 20'hE0211, 4'b0000);
        cyc_full(4'd0, 1, 0, 0, 3'd0, 4'hF, 4'd0, 0, 1'b0);
        cyc_full(4'd1, 0, 0, 0, 3'd0, 4'hF, 4'd1, 0, 1'b0);
        cyc_full(4'd6, 0, 0, 0, 3'd4, 4'hF, 4'd0, 0, 1'b0);
        cyc_full(4'd8, 0, 0, 1, 3'd0, 4'hF, 4'd1, 0, 1'b0);

        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
